score_display: RTL
==================

SCORE_DISPLAY -- requirements
Module: score_display

Interface
REQ-001 SHALL have parameter BW, default 7, bit width of the score value.
REQ-002 SHALL have parameter REFRESH_BITS, default 16, width of the digit-multiplex refresh counter (set to 4 in simulation).
REQ-003 SHALL have port clk_i  input  1  system clock; the only clock.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port counter_val_i  input  BW  score from the up/down counter; asynchronous to clk_i; legal range 0-99.
REQ-006 SHALL have port seg_o  output  7  segment drive, active-high, bit order {g,f,e,d,c,b,a}.
REQ-007 SHALL have port dig_sel_o  output  2  one-hot digit enable: 2'b01 selects ones, 2'b10 selects tens.
REQ-008 SHALL have port bcd_tens_o  output  4  registered tens digit.
REQ-009 SHALL have port bcd_ones_o  output  4  registered ones digit.
REQ-010 SHALL have port busy_o  output  1  high while a conversion is in progress.

Function
REQ-011 SHALL pass counter_val_i through a 2-flop synchronizer and accept a sample only when two consecutive synchronized samples are equal (stable value).
REQ-012 SHALL use FSM states IDLE and CONV; IDLE->CONV when the stable value differs from last_val; CONV->IDLE after BW shift cycles.
REQ-013 SHALL, on entering CONV, capture the stable value into last_val and the converter shift register.
REQ-014 SHALL convert binary to BCD by sequential shift-and-add-3 (double dabble): one bit per cycle, MSB first, BW cycles in total.
REQ-015 SHALL update bcd_tens_o/bcd_ones_o on the clock edge after the last shift, both digits on the same edge, never partially.
REQ-016 SHALL update the digits within BW+5 clk_i cycles of counter_val_i becoming stable.
REQ-017 SHALL ignore input changes during CONV and re-evaluate them in IDLE, so the final displayed value equals the last stable input.
REQ-018 SHALL assert busy_o exactly while in CONV.
REQ-019 SHALL flag captured values >99 as overflow, leave the BCD registers unchanged, and drive 7'h40 (dash) on both digits until an in-range value is converted.
REQ-020 SHALL free-run the REFRESH_BITS counter with wrap-around; its MSB selects the digit (0 = ones, 1 = tens).
REQ-021 SHALL register seg_o and dig_sel_o together each cycle, so the segment pattern always matches the enabled digit.
REQ-022 SHALL encode digits 0-9 as 3F,06,5B,4F,66,6D,7D,07,7F,6F (hex).
REQ-023 SHALL blank the tens digit (seg_o = 7'h00 during the tens phase) when bcd_tens_o = 0 and there is no overflow.

Reset
REQ-024 SHALL, with rst_i low, asynchronously force: state IDLE; busy_o 0; last_val 0; bcd_tens_o 0; bcd_ones_o 0; overflow 0; refresh counter 0; seg_o 7'h00; dig_sel_o 2'b01; synchronizer flops 0.
REQ-025 SHALL abort a conversion interrupted by reset without any digit update, and restart from IDLE after reset release.

Structure
REQ-026 SHALL place the segment code table, the dash code 7'h40 and the digit-select encodings in the shared package scoreboard_pkg.
REQ-027 SHALL implement the sequential converter as sub-module bin2bcd_seq (start/done handshake, BW-cycle latency); synchronizer, FSM and multiplexer stay in score_display.

Verification (REFRESH_BITS = 4)
REQ-028 SHALL check: reset with input 0 -> after release, ones phase seg_o=3F, tens phase seg_o=00, busy_o never asserts.
REQ-029 SHALL check: input 42 held -> within 12 cycles bcd_tens_o=4, bcd_ones_o=2; ones phase seg_o=5B with dig_sel_o=01; tens phase seg_o=66 with dig_sel_o=10.
REQ-030 SHALL check: input 42, then 43 applied 3 cycles into CONV -> a second conversion follows; final digits 4/3, and 42 is never displayed after 43 is stable.
REQ-031 SHALL check: input 99 -> both phases seg_o=6F; input 7 -> tens phase seg_o=00, ones phase seg_o=07.
REQ-032 SHALL check: input 110 -> both phases seg_o=40; then input 5 -> ones seg_o=6D, tens blanked.
REQ-033 SHALL check: rst_i pulsed low mid-CONV while converting 63 -> immediate reset values, then after release the display converges to 6/3.

Source files
------------

// File: rtl/scoreboard_pkg.sv
// Shared definitions for the score display: FSM states, 7-segment codes, digit-select encodings.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package scoreboard_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_e;

    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [1:0] DIG_ONES  = 2'b01;
    localparam logic [1:0] DIG_TENS  = 2'b10;

    // Number of BCD digits needed to hold 2^bw - 1 (log10(2) ~ 0.301).
    function automatic int bcd_digits(input int bw);
        int n;
        n = (bw * 301 + 999) / 1000;
        return (n < 2) ? 2 : n;
    endfunction

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: start_i loads bin_i, then one bit per cycle MSB first.
// done_o pulses one cycle after the BW-th shift; start_i is ignored while busy.
module bin2bcd_seq
    import scoreboard_pkg::*;
#(
    parameter  int BW = 7,
    localparam int ND = bcd_digits(BW)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [BW-1:0]   bin_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [4*ND-1:0] bcd_o
);

    localparam int CW = $clog2(BW + 1);

    logic [BW-1:0]   sh_q, sh_d;
    logic [4*ND-1:0] bcd_q, bcd_d, adj;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < ND; i++) begin
            if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        sh_d   = sh_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start_i && !busy_q) begin
            sh_d   = bin_i;
            bcd_d  = '0;
            cnt_d  = CW'(BW);
            busy_d = 1'b1;
        end else if (busy_q) begin
            {bcd_d, sh_d} = {adj[4*ND-2:0], sh_q, 1'b0};
            cnt_d         = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sh_q   <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/score_display.sv
// Two-digit 7-segment score display: synchronizes an async score, converts it to BCD and multiplexes digits.
// Digits update at most BW+5 cycles after the input settles; input changes during a conversion wait for IDLE.
module score_display
    import scoreboard_pkg::*;
#(
    parameter int BW           = 7,
    parameter int REFRESH_BITS = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [BW-1:0] counter_val_i,
    output logic [6:0]    seg_o,
    output logic [1:0]    dig_sel_o,
    output logic [3:0]    bcd_tens_o,
    output logic [3:0]    bcd_ones_o,
    output logic          busy_o
);

    localparam int ND = bcd_digits(BW);

    logic [BW-1:0]           s1_q, s2_q, s3_q;
    logic [BW-1:0]           last_val_q;
    state_e                  state_q, state_d;
    logic                    start, conv_done, stable;
    logic [4*ND-1:0]         conv_bcd;
    logic [3:0]              tens_q, ones_q;
    logic                    ovf_q;
    logic [REFRESH_BITS-1:0] refresh_q;
    logic [6:0]              seg_q, seg_d;
    logic [1:0]              dig_sel_q, dig_sel_d;

    // s3_q holds the previous synchronized sample so a value is only trusted once seen twice.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= counter_val_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign stable = (s2_q == s3_q);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (stable && (s2_q != last_val_q)) state_d = ST_CONV;
            ST_CONV: if (conv_done) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q == ST_CONV);
        start  = (state_q == ST_IDLE) && (state_d == ST_CONV);
    end

    bin2bcd_seq #(.BW(BW)) u_conv (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start),
        .bin_i   (s2_q),
        .busy_o  (),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_val_q <= '0;
            tens_q     <= '0;
            ones_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            if (start) last_val_q <= s2_q;
            if (conv_done && state_q == ST_CONV) begin
                if (int'(last_val_q) > 99) begin
                    ovf_q <= 1'b1;
                end else begin
                    tens_q <= conv_bcd[7:4];
                    ones_q <= conv_bcd[3:0];
                    ovf_q  <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        seg_d     = seg_encode(ones_q);
        dig_sel_d = DIG_ONES;
        if (refresh_q[REFRESH_BITS-1]) begin
            dig_sel_d = DIG_TENS;
            seg_d     = (tens_q == 4'd0) ? SEG_BLANK : seg_encode(tens_q);
        end
        if (ovf_q) seg_d = SEG_DASH;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            refresh_q <= '0;
            seg_q     <= SEG_BLANK;
            dig_sel_q <= DIG_ONES;
        end else begin
            refresh_q <= refresh_q + 1'b1;
            seg_q     <= seg_d;
            dig_sel_q <= dig_sel_d;
        end
    end

    assign seg_o      = seg_q;
    assign dig_sel_o  = dig_sel_q;
    assign bcd_tens_o = tens_q;
    assign bcd_ones_o = ones_q;

endmodule
